charge_session_ctrl: RTL
========================

# charge_session_ctrl

Session controller for the coin-operated charger. Consumes decoded keypad events, builds the paid amount (one or two digits, capped at 20), converts it to charge time (2 s per unit), runs the 1 Hz countdown, and drives the charge-enable output. It sits between the keypad decoder and the display/relay drivers, and owns all sequencing of the amount/time datapath.

## Interface
Parameters:
- CLK_HZ, 1000 — clk frequency; prescaler divides to 1 Hz.
- MAX_MONEY, 20 — amount cap.
- SEC_PER_UNIT, 2 — seconds of charge per money unit.
- IDLE_TIMEOUT_S, 10 — seconds without a key in an entry state before abandoning entry.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-high; clock clk.
- key_valid  in  1  one-cycle pulse, key_code valid.
- key_code  in  4  0–9 digit; 10 = START; 11 = CLEAR; 12–15 ignored.
- charging  out  1  relay enable; high only in CHARGE.
- money  out  5  current amount, binary.
- remaining_time  out  6  seconds left, binary.
- state  out  2  current state, for the display mux.
- done  out  1  one-cycle pulse when a countdown reaches 0.

## Operation
- States: IDLE(00), ENTRY1(01), ENTRY2(10), CHARGE(11).
- IDLE: digit d → ENTRY1, money=d. START/CLEAR are ignored.
- ENTRY1: digit d → ENTRY2, money=min(10·money+d, MAX_MONEY). START with money≠0 → CHARGE. START with money=0 is ignored. CLEAR → IDLE.
- ENTRY2: further digits are ignored. START with money≠0 → CHARGE. START with money=0 is ignored. CLEAR → IDLE.
- CHARGE: digits and START are ignored. CLEAR aborts to IDLE with no done pulse. When remaining_time is 1 and a tick occurs, remaining_time becomes 0, the FSM goes to IDLE, and done pulses.
- remaining_time = money·SEC_PER_UNIT in ENTRY1/ENTRY2, updated in the same cycle as money. Maximum is 40, which fits in 6 bits.
- Arithmetic: 10·money+d is computed at 7 bits (max 99) before the cap compare, so there is no truncation.
- Idle timeout: a seconds counter runs in ENTRY1/ENTRY2 and is cleared on every key_valid. Reaching IDLE_TIMEOUT_S → IDLE.
- Entering IDLE clears money and remaining_time to 0.
- Reset: state=IDLE; money=0; remaining_time=0; charging=0; done=0; prescaler and timeout counters=0. Reset mid-CHARGE drops charging asynchronously.

## Timing
- All outputs are registered. A key_valid sampled at posedge N is reflected in state/money/remaining_time after edge N (visible in cycle N+1).
- charging rises in the cycle after START is sampled.
- The prescaler is cleared on every state change and on every key_valid in entry states. A tick is a one-cycle pulse every CLK_HZ cycles.
- First decrement occurs exactly CLK_HZ cycles after CHARGE entry. A session of money m lasts m·SEC_PER_UNIT·CLK_HZ cycles in CHARGE.
- On the final tick: remaining_time=0, state=IDLE, charging=0, and done=1, all in the same cycle. done lasts one cycle.
- Simultaneous events: CLEAR in the same cycle as the final tick → abort path wins (IDLE, no done). Timeout and key_valid in the same cycle → the key wins and the timeout counter clears.

## Structure
- Shared package charger_pkg: state encoding constants, key codes (KEY_START=10, KEY_CLEAR=11), MAX_MONEY, SEC_PER_UNIT.
- Sub-module tick_gen: parameter CLK_HZ; inputs clk, rst_n, clr; output tick (one-cycle 1 Hz pulse). It is instantiated once and shared by the countdown and the idle timeout.
- FSM, amount arithmetic and counters live in charge_session_ctrl.

## Test plan
- Keys 1,5,START → money=15, remaining_time=30, charging high for 30·CLK_HZ cycles, then done pulse, state=IDLE, remaining_time=0.
- Keys 9,9 → money=20, remaining_time=40. Key 3 (a third digit) leaves money=20. START → CHARGE.
- Keys 0,START → START ignored, state stays ENTRY1. Key 4,START → money=4, CHARGE for 8 s.
- Keys 7,START, then CLEAR after 3 s → state=IDLE, charging=0, money=0, no done pulse. Digit keys during CHARGE leave money unchanged.
- Key 2, then no input for 10 s → IDLE, money=0. A key at 9.9 s restarts the 10 s window.
- Assert rst_n mid-CHARGE → charging=0 immediately. After release, state=IDLE and all outputs are 0.

Source files
------------

// File: rtl/charger_pkg.sv
// Shared definitions for the coin-operated charger session logic.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
//
// Holds the display-visible state encoding, the keypad codes the session
// controller reacts to, and the default money/time scaling constants.
package charger_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ENTRY1 = 2'b01,
        ST_ENTRY2 = 2'b10,
        ST_CHARGE = 2'b11
    } state_t;

    localparam logic [3:0] KEY_START = 4'd10;
    localparam logic [3:0] KEY_CLEAR = 4'd11;

    localparam int unsigned MAX_MONEY    = 20;
    localparam int unsigned SEC_PER_UNIT = 2;

    // Charge seconds bought by an amount; callers keep the product within 6 bits.
    function automatic logic [5:0] secs_for(input logic [4:0] m, input int unsigned spu);
        return 6'(32'(m) * spu);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// 1 Hz tick prescaler shared by the charge countdown and the entry idle timeout.
// Latency: first tick is CLK_HZ cycles after the edge that samples clr.
// Backpressure: none; tick is a free-running one-cycle pulse.
//
// Ports: clk, rst_n (async, asserted high), clr (restart the second),
//        tick (high for one cycle once every CLK_HZ cycles).
module tick_gen #(
    parameter int unsigned CLK_HZ = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned W = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_HZ - 1);

    logic [W-1:0] cnt;

    // tick is decoded from the count register, not from clr, so the session
    // FSM can derive clr from its next state without a combinational loop.
    assign tick = (cnt == LAST);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/charge_session_ctrl.sv
// Charger session controller: keypad amount entry, amount-to-time, 1 Hz countdown, relay enable.
// Latency: every output is registered; a key sampled at edge N shows after edge N.
// Backpressure: none; key_valid pulses are consumed or ignored in the cycle they arrive.
//
// Ports: clk, rst_n (async, asserted high), key_valid/key_code (decoded keypad),
//        charging (relay), money, remaining_time, state (display mux), done (end pulse).
module charge_session_ctrl
    import charger_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 1000,
    parameter int unsigned MAX_MONEY      = charger_pkg::MAX_MONEY,
    parameter int unsigned SEC_PER_UNIT   = charger_pkg::SEC_PER_UNIT,
    parameter int unsigned IDLE_TIMEOUT_S = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       charging,
    output logic [4:0] money,
    output logic [5:0] remaining_time,
    output logic [1:0] state,
    output logic       done
);

    localparam int unsigned TW = (IDLE_TIMEOUT_S > 1) ? $clog2(IDLE_TIMEOUT_S + 1) : 1;

    state_t        state_q, state_n;
    logic [4:0]    money_n;
    logic [5:0]    rtime_n;
    logic [TW-1:0] to_cnt, to_cnt_n;
    logic          done_n;
    logic          tick;
    logic          presc_clr;
    logic          in_entry;
    logic          is_digit, is_start, is_clear;
    logic [6:0]    sum7;

    assign in_entry = (state_q == ST_ENTRY1) || (state_q == ST_ENTRY2);
    assign is_digit = (key_code <= 4'd9);
    assign is_start = (key_code == KEY_START);
    assign is_clear = (key_code == KEY_CLEAR);

    // Two-digit amount at 7 bits so 99 is representable before capping.
    assign sum7 = ({2'b00, money} * 7'd10) + {3'b000, key_code};

    // Restart the second on any state change and on every key during entry,
    // so both the countdown and the idle window are measured from that edge.
    assign presc_clr = (state_n != state_q) || (key_valid && in_entry);

    tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (presc_clr),
        .tick  (tick)
    );

    always_comb begin
        state_n  = state_q;
        money_n  = money;
        rtime_n  = remaining_time;
        to_cnt_n = to_cnt;
        done_n   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (key_valid && is_digit) begin
                    state_n = ST_ENTRY1;
                    money_n = {1'b0, key_code};
                    rtime_n = secs_for(money_n, SEC_PER_UNIT);
                end
            end
            ST_ENTRY1, ST_ENTRY2: begin
                if (key_valid) begin
                    // A key always beats a coincident timeout.
                    to_cnt_n = '0;
                    if (is_digit && state_q == ST_ENTRY1) begin
                        state_n = ST_ENTRY2;
                        money_n = (sum7 > 7'(MAX_MONEY)) ? 5'(MAX_MONEY) : sum7[4:0];
                        rtime_n = secs_for(money_n, SEC_PER_UNIT);
                    end else if (is_start && money != 5'd0) begin
                        state_n = ST_CHARGE;
                    end else if (is_clear) begin
                        state_n = ST_IDLE;
                    end
                end else if (tick) begin
                    if (to_cnt == TW'(IDLE_TIMEOUT_S - 1)) begin
                        state_n = ST_IDLE;
                    end else begin
                        to_cnt_n = to_cnt + TW'(1);
                    end
                end
            end
            ST_CHARGE: begin
                // Abort has priority over a coincident final tick: no done pulse.
                if (key_valid && is_clear) begin
                    state_n = ST_IDLE;
                end else if (tick) begin
                    rtime_n = remaining_time - 6'd1;
                    if (remaining_time == 6'd1) begin
                        state_n = ST_IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if (state_n == ST_IDLE) begin
            money_n = 5'd0;
            rtime_n = 6'd0;
        end
        if (state_n != ST_ENTRY1 && state_n != ST_ENTRY2) begin
            to_cnt_n = '0;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q        <= ST_IDLE;
            money          <= 5'd0;
            remaining_time <= 6'd0;
            to_cnt         <= '0;
            done           <= 1'b0;
            charging       <= 1'b0;
        end else begin
            state_q        <= state_n;
            money          <= money_n;
            remaining_time <= rtime_n;
            to_cnt         <= to_cnt_n;
            done           <= done_n;
            charging       <= (state_n == ST_CHARGE);
        end
    end

    assign state = state_q;

endmodule
